// File: rtl/cache_way_ctrl.sv
`default_nettype none
// ============================================================================
// cache_way_ctrl : write-through request controller for one direct-mapped way
// Option: CACHE_WAY_CTRL_WRITE_ALLOCATE_EN enables write-allocate on write miss
// Rev 1.0
// ============================================================================
module cache_way_ctrl #(
  parameter int CACHE_WAY_ADDR_WIDTH      = 7,
  parameter int CACHE_WAY_DATA_WIDTH      = 32,
  parameter int CACHE_WAY_DATA_SIZE_BYTES = 4,
  parameter int CACHE_WAY_TAG_WIDTH       = 4
) (
  input  logic                                                clk,
  input  logic                                                reset_n,
  input  logic                                                i_req_valid,
  output logic                                                o_req_ready,
  input  logic                                                i_req_we,
  input  logic [CACHE_WAY_TAG_WIDTH+CACHE_WAY_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [CACHE_WAY_DATA_SIZE_BYTES-1:0]                i_req_ben,
  input  logic [CACHE_WAY_DATA_WIDTH-1:0]                     i_req_wdata,
  output logic                                                o_rsp_valid,
  output logic [CACHE_WAY_DATA_WIDTH-1:0]                     o_rsp_rdata,
  output logic                                                o_rsp_hit,
  output logic [CACHE_WAY_ADDR_WIDTH-1:0]                     o_cache_way_addr,
  output logic                                                o_cache_way_wen,
  output logic [CACHE_WAY_DATA_SIZE_BYTES-1:0]                o_cache_way_ben,
  output logic [CACHE_WAY_DATA_WIDTH-1:0]                     o_cache_way_data,
  input  logic [CACHE_WAY_DATA_WIDTH-1:0]                     i_cache_way_data,
  output logic                                                o_tag_wen,
  output logic [CACHE_WAY_TAG_WIDTH-1:0]                      o_tag_data,
  input  logic [CACHE_WAY_TAG_WIDTH-1:0]                      i_tag_data,
  output logic                                                o_mem_req_valid,
  input  logic                                                i_mem_req_ready,
  output logic                                                o_mem_req_we,
  output logic [CACHE_WAY_TAG_WIDTH+CACHE_WAY_ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [CACHE_WAY_DATA_SIZE_BYTES-1:0]                o_mem_req_ben,
  output logic [CACHE_WAY_DATA_WIDTH-1:0]                     o_mem_req_wdata,
  input  logic                                                i_mem_rsp_valid,
  input  logic [CACHE_WAY_DATA_WIDTH-1:0]                     i_mem_rsp_data
);

  localparam int c_AW      = CACHE_WAY_TAG_WIDTH + CACHE_WAY_ADDR_WIDTH;
  localparam int c_IDX_W   = CACHE_WAY_ADDR_WIDTH - 2;
  localparam int c_ENTRIES = 1 << c_IDX_W;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOOKUP   = 4'd1,
    S_COMPARE  = 4'd2,
    S_WRITE    = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WAIT = 4'd5,
    S_FILL     = 4'd6,
    S_MEM_WR   = 4'd7,
    S_RESP     = 4'd8
  } state_t;

  state_t                                 r_state;
  state_t                                 w_next;
  logic                                   r_we;
  logic [c_AW-3:0]                        r_word;
  logic [CACHE_WAY_DATA_SIZE_BYTES-1:0]   r_ben;
  logic [CACHE_WAY_DATA_WIDTH-1:0]        r_wdata;
  logic [CACHE_WAY_DATA_WIDTH-1:0]        r_rdata;
  logic                                   r_hit;
  logic [c_ENTRIES-1:0]                   r_valid;

  logic [CACHE_WAY_TAG_WIDTH-1:0]         w_tag;
  logic [c_IDX_W-1:0]                     w_index;
  logic                                   w_hit;
  logic [CACHE_WAY_DATA_WIDTH-1:0]        w_fill_data;
  logic                                   w_unused_addr_bits;

  // Word address only: the byte offset is defined as don't-care.
  assign w_unused_addr_bits = ^i_req_addr[1:0];
  assign w_tag              = r_word[c_AW-3 -: CACHE_WAY_TAG_WIDTH];
  assign w_index            = r_word[c_IDX_W-1:0];
  assign w_hit              = r_valid[w_index] && (i_tag_data == w_tag);

  assign o_cache_way_addr = {w_index, 2'b00};
  assign o_mem_req_addr   = {r_word, 2'b00};

  // r_rdata holds memory data during a write-allocate fill; request bytes win.
`ifdef CACHE_WAY_CTRL_WRITE_ALLOCATE_EN
  always_comb begin
    w_fill_data = r_rdata;
    for (int i = 0; i < CACHE_WAY_DATA_SIZE_BYTES; i++) begin
      if (r_we && r_ben[i]) w_fill_data[i*8 +: 8] = r_wdata[i*8 +: 8];
    end
  end
`else
  assign w_fill_data = r_rdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_word  <= '0;
      r_ben   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_hit   <= 1'b0;
      r_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_word  <= i_req_addr[c_AW-1:2];
            r_ben   <= i_req_ben;
            r_wdata <= i_req_wdata;
            r_rdata <= '0;
            r_hit   <= 1'b0;
          end
        end
        S_COMPARE: begin
          r_hit <= w_hit;
          if (!r_we) r_rdata <= i_cache_way_data;
        end
        S_MEM_WAIT: if (i_mem_rsp_valid) r_rdata <= i_mem_rsp_data;
        S_FILL:     r_valid[w_index] <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    o_req_ready      = 1'b0;
    o_rsp_valid      = 1'b0;
    o_rsp_rdata      = '0;
    o_rsp_hit        = 1'b0;
    o_cache_way_wen  = 1'b0;
    o_cache_way_ben  = '0;
    o_cache_way_data = '0;
    o_tag_wen        = 1'b0;
    o_tag_data       = '0;
    o_mem_req_valid  = 1'b0;
    o_mem_req_we     = 1'b0;
    o_mem_req_ben    = '0;
    o_mem_req_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: w_next = S_COMPARE;
      S_COMPARE: begin
        if (w_hit)      w_next = r_we ? S_WRITE : S_RESP;
        else if (!r_we) w_next = S_MEM_RD;
        else begin
`ifdef CACHE_WAY_CTRL_WRITE_ALLOCATE_EN
          w_next = S_MEM_RD;
`else
          w_next = S_MEM_WR;
`endif
        end
      end
      S_WRITE: begin
        o_cache_way_wen  = 1'b1;
        o_cache_way_ben  = r_ben;
        o_cache_way_data = r_wdata;
        w_next           = S_MEM_WR;
      end
      S_MEM_RD: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_ben   = '1;
        if (i_mem_req_ready) w_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: if (i_mem_rsp_valid) w_next = S_FILL;
      S_FILL: begin
        o_cache_way_wen  = 1'b1;
        o_cache_way_ben  = '1;
        o_cache_way_data = w_fill_data;
        o_tag_wen        = 1'b1;
        o_tag_data       = w_tag;
        w_next           = r_we ? S_MEM_WR : S_RESP;
      end
      S_MEM_WR: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_we    = 1'b1;
        o_mem_req_ben   = r_ben;
        o_mem_req_wdata = r_wdata;
        if (i_mem_req_ready) w_next = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = r_we ? '0 : r_rdata;
        o_rsp_hit   = r_hit;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/cache_way_ctrl.md
# cache_way_ctrl

Request-side controller for one direct-mapped cache way: accepts word read/write requests from the core, drives the cache way's single data/tag port, compares tags, and refills or writes through to memory over a simple valid/ready memory port. It is the initiator that owns every `cache_way` data and tag access. Policy is write-through, one 32-bit word per line, with valid bits held internally.

## Interface
Parameters:
- CACHE_WAY_ADDR_WIDTH, 7: byte index width into the way; entries = 2^(ADDR_WIDTH-2).
- CACHE_WAY_DATA_WIDTH, 32: word width.
- CACHE_WAY_DATA_SIZE_BYTES, 4: byte-enable width.
- CACHE_WAY_TAG_WIDTH, 4: tag width; request address width AW = TAG_WIDTH + ADDR_WIDTH.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_req_valid / o_req_ready  in/out  1  core request handshake.
- i_req_we  in  1  1 = write.
- i_req_addr  in  AW  byte address; bits [1:0] ignored (treated as 0).
- i_req_ben  in  BYTES  write byte enables.
- i_req_wdata  in  DATA  write data.
- o_rsp_valid  out  1  one-cycle response pulse, no backpressure.
- o_rsp_rdata  out  DATA  read data; 0 for writes.
- o_rsp_hit  out  1  lookup hit.
- o_cache_way_addr  out  ADDR  way index, low 2 bits always 0.
- o_cache_way_wen, o_cache_way_ben, o_cache_way_data  out  1/BYTES/DATA  way data write.
- i_cache_way_data  in  DATA  way read data, valid one cycle after address.
- o_tag_wen, o_tag_data  out  1/TAG  way tag write.
- i_tag_data  in  TAG  way tag read, valid one cycle after address.
- o_mem_req_valid / i_mem_req_ready  out/in  1  memory request handshake.
- o_mem_req_we, o_mem_req_addr, o_mem_req_ben, o_mem_req_wdata  out  1/AW/BYTES/DATA  memory request payload, stable while valid.
- i_mem_rsp_valid, i_mem_rsp_data  in  1/DATA  memory read return.

## Operation
- Address split: tag = addr[AW-1:ADDR_WIDTH]; index = addr[ADDR_WIDTH-1:2]; o_cache_way_addr = {index, 2'b00}.
- Valid array: one bit per entry, cleared by reset. hit = valid[index] && (i_tag_data == tag).
- FSM: IDLE, LOOKUP, COMPARE, WRITE, MEM_RD, MEM_WAIT, FILL, MEM_WR, RESP. o_req_ready = (state == IDLE).
- IDLE to LOOKUP on accept: capture request and drive o_cache_way_addr. LOOKUP to COMPARE: way outputs valid. COMPARE branches on op and hit.
- Read hit: RESP, with rdata = i_cache_way_data and hit = 1.
- Read miss: MEM_RD (we = 0, ben all ones), hold valid until ready; then MEM_WAIT until i_mem_rsp_valid. FILL pulses o_cache_way_wen (ben all ones, data = memory data) and o_tag_wen (tag), and sets valid. Then RESP with rdata = memory data and hit = 0.
- Write hit: WRITE pulses o_cache_way_wen with i_req_ben and wdata. Then MEM_WR (we = 1, same ben/data), then RESP with hit = 1.
- Write miss: behaviour depends on configuration (see below). ben = 0 is legal: the write is forwarded as-is and no bytes change.
- i_mem_rsp_valid outside MEM_WAIT is ignored.
- Conflict miss overwrites the entry. There is no writeback, because the cache is write-through.

## Timing
- Reset value of every output is 0 except o_req_ready = 1. Reset forces IDLE asynchronously and clears all valid bits. An in-flight memory request is abandoned.
- Read hit: accept at edge E; o_rsp_valid sampled high at edge E+3. o_req_ready returns at E+4. Maximum accept rate is 1 per 4 cycles.
- o_cache_way_wen and o_tag_wen are exactly one cycle wide. No way read is issued in the cycle after a way write; the FSM guarantees this by passing through RESP and IDLE.
- Memory request completes on the edge where valid && ready. Payload must not change while valid is high.
- Miss latency = 5 + memory request wait + memory response wait cycles.

## Configuration
- CACHE_WAY_CTRL_WRITE_ALLOCATE_EN defined: a write miss goes MEM_RD → MEM_WAIT → FILL → MEM_WR → RESP. FILL writes merged data (request bytes where ben = 1, memory bytes elsewhere) with ben all ones, writes the tag, and sets valid.
- Macro undefined: a write miss goes MEM_WR → RESP. The way is untouched and valid is unchanged.
- In both cases o_rsp_hit = 0 on a write miss.

## Test plan
- After reset, read 0x004; memory returns 0xDEADBEEF. Required: memory read at addr 0x004; way write at addr 0x04 with tag 0; response rdata 0xDEADBEEF, hit 0.
- Read 0x004 again. Required: hit 1, rdata 0xDEADBEEF, no o_mem_req_valid, o_rsp_valid at accept edge + 3.
- Write 0x004 with ben 0b0011, data 0x00001234. Required: way write with ben 0011, memory write with ben 0011, hit 1. A following read of 0x004 returns 0xDEAD1234, hit 1.
- Read 0x084 (tag 1, index 1). Required: miss, tag 1 written. A following read of 0x004 misses.
- Write miss to 0x010 with data 0xA5A5A5A5, ben 1111. Required without the macro: memory write only, and a following read of 0x010 misses. Required with the macro: memory read, fill, memory write, and a following read hits with 0xA5A5A5A5.
- Assert reset_n = 0 during MEM_WAIT, release it, then pulse i_mem_rsp_valid. Required: outputs reset immediately and the pulse is ignored. A following read of 0x004 misses.
